bpsk_deinterleaver: RTL and testbench

Receive-chain stage between the demapper and `ViterbiDecoder`. It undoes the 802.11a block interleaver for BPSK symbols (N_CBPS = 48, N_BPSC = 1, so the second permutation is the identity). It collects 48 hard-decision coded bits per OFDM symbol into a ping-pong buffer, then streams them out in deinterleaved order, one bit per cycle. The output stream is the coded-bit stream the Viterbi decoder consumes.

---
 rtl/bpsk_deinterleaver_if.sv | 20 ++
 rtl/bpsk_deinterleaver.sv | 150 +++++++++++++++
 tb/tb_bpsk_deinterleaver.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bpsk_deinterleaver_if.sv
// Bit-stream interface between the BPSK demapper, the deinterleaver and the Viterbi decoder.
// master drives coded bits and Clear; slave returns the deinterleaved stream.
interface bpsk_deinterleaver_if;
    logic Input;
    logic InValid;
    logic Clear;
    logic Output;
    logic OutValid;
    logic SymbolDone;

    modport master (
        output Input, InValid, Clear,
        input  Output, OutValid, SymbolDone
    );

    modport slave (
        input  Input, InValid, Clear,
        output Output, OutValid, SymbolDone
    );
endinterface

// File: rtl/bpsk_deinterleaver.sv
// 802.11a BPSK block deinterleaver: writes each symbol permuted into a ping-pong bank,
// then streams the bank out in order, one coded bit per cycle.
module bpsk_deinterleaver #(
    parameter int unsigned N_CBPS = 48
) (
    input logic                 Clock,
    input logic                 Reset,
    bpsk_deinterleaver_if.slave bus
);
    localparam int unsigned Cols = N_CBPS / 16;
    localparam int unsigned CntW = $clog2(N_CBPS);
    localparam int unsigned ColW = (Cols > 1) ? $clog2(Cols) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(N_CBPS - 1);
    localparam logic [ColW-1:0] LastCol = ColW'(Cols - 1);

    typedef enum logic [0:0] {StIdle, StRead} state_e;

    state_e                  state_q, state_d;
    logic [1:0][N_CBPS-1:0]  bank_q;
    logic [1:0]              full_q, full_d;
    logic [CntW-1:0]         wr_cnt_q, wr_cnt_d;
    logic [CntW-1:0]         rd_cnt_q, rd_cnt_d;
    logic [ColW-1:0]         wr_mod3_q, wr_mod3_d;
    logic [3:0]              wr_div3_q, wr_div3_d;
    logic                    wr_bank_q, wr_bank_d;
    logic                    rd_bank_q, rd_bank_d;
    logic                    out_bit_q, out_bit_d;
    logic                    out_valid_q, out_valid_d;
    logic                    sym_done_q, sym_done_d;
    logic                    wr_accept, wr_last, rd_release, other_full;
    logic [CntW-1:0]         wr_addr;

    assign wr_accept = bus.InValid & ~bus.Clear;
    assign wr_last   = wr_accept & (wr_cnt_q == LastCnt);
    // k = 16*(j mod Cols) + floor(j/Cols), tracked incrementally without a divider.
    assign wr_addr   = CntW'({wr_mod3_q, wr_div3_q});
    // Also sees a bank completing on this very edge, so reads chain without a bubble.
    assign other_full = full_q[~rd_bank_q] | (wr_last & (wr_bank_q != rd_bank_q));

    always_comb begin
        wr_cnt_d  = wr_cnt_q;
        wr_mod3_d = wr_mod3_q;
        wr_div3_d = wr_div3_q;
        wr_bank_d = wr_bank_q;
        if (bus.Clear) begin
            wr_cnt_d  = '0;
            wr_mod3_d = '0;
            wr_div3_d = '0;
            wr_bank_d = 1'b0;
        end else if (wr_accept) begin
            if (wr_last) begin
                wr_cnt_d  = '0;
                wr_mod3_d = '0;
                wr_div3_d = '0;
                wr_bank_d = ~wr_bank_q;
            end else begin
                wr_cnt_d = wr_cnt_q + CntW'(1);
                if (wr_mod3_q == LastCol) begin
                    wr_mod3_d = '0;
                    wr_div3_d = wr_div3_q + 4'd1;
                end else begin
                    wr_mod3_d = wr_mod3_q + ColW'(1);
                end
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        rd_cnt_d    = rd_cnt_q;
        rd_bank_d   = rd_bank_q;
        out_bit_d   = 1'b0;
        out_valid_d = 1'b0;
        sym_done_d  = 1'b0;
        rd_release  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (full_q[rd_bank_q]) begin
                    state_d  = StRead;
                    rd_cnt_d = '0;
                end
            end
            StRead: begin
                out_bit_d   = bank_q[rd_bank_q][rd_cnt_q];
                out_valid_d = 1'b1;
                rd_cnt_d    = rd_cnt_q + CntW'(1);
                if (rd_cnt_q == LastCnt) begin
                    sym_done_d = 1'b1;
                    rd_release = 1'b1;
                    rd_bank_d  = ~rd_bank_q;
                    rd_cnt_d   = '0;
                    if (!other_full) state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        if (bus.Clear) begin
            state_d     = StIdle;
            rd_cnt_d    = '0;
            rd_bank_d   = 1'b0;
            out_bit_d   = 1'b0;
            out_valid_d = 1'b0;
            sym_done_d  = 1'b0;
        end
    end

    always_comb begin
        full_d = full_q;
        if (rd_release) full_d[rd_bank_q] = 1'b0;
        if (wr_last)    full_d[wr_bank_q] = 1'b1;
        if (bus.Clear)  full_d = '0;
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q     <= StIdle;
            full_q      <= '0;
            wr_cnt_q    <= '0;
            rd_cnt_q    <= '0;
            wr_mod3_q   <= '0;
            wr_div3_q   <= '0;
            wr_bank_q   <= 1'b0;
            rd_bank_q   <= 1'b0;
            out_bit_q   <= 1'b0;
            out_valid_q <= 1'b0;
            sym_done_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            full_q      <= full_d;
            wr_cnt_q    <= wr_cnt_d;
            rd_cnt_q    <= rd_cnt_d;
            wr_mod3_q   <= wr_mod3_d;
            wr_div3_q   <= wr_div3_d;
            wr_bank_q   <= wr_bank_d;
            rd_bank_q   <= rd_bank_d;
            out_bit_q   <= out_bit_d;
            out_valid_q <= out_valid_d;
            sym_done_q  <= sym_done_d;
        end
    end

    // Bank storage needs no reset; full flags guard every read.
    always_ff @(posedge Clock) begin
        if (wr_accept) bank_q[wr_bank_q][wr_addr] <= bus.Input;
    end

    assign bus.Output     = out_bit_q;
    assign bus.OutValid   = out_valid_q;
    assign bus.SymbolDone = sym_done_q;
endmodule

// File: tb/tb_bpsk_deinterleaver.sv
// Directed self-checking bench for bpsk_deinterleaver: single-one, permutation, back-to-back,
// gapped, Clear and reset-mid-read scenarios.
module tb_bpsk_deinterleaver;
    logic Clock = 1'b0;
    logic Reset;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   last_edge = 0;

    logic obs_bit[$];
    int   obs_cyc[$];
    logic obs_done[$];
    int   stray_done[$];

    always #5 Clock = ~Clock;

    bpsk_deinterleaver_if bus ();

    bpsk_deinterleaver #(.N_CBPS(48)) dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus)
    );

    always @(posedge Clock) cyc <= cyc + 1;

    always @(negedge Clock) begin
        if (bus.OutValid === 1'b1) begin
            obs_bit.push_back(bus.Output);
            obs_cyc.push_back(cyc);
            obs_done.push_back(bus.SymbolDone);
        end else if (bus.SymbolDone === 1'b1) begin
            stray_done.push_back(cyc);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    function automatic logic [47:0] deint(input logic [47:0] din);
        logic [47:0] r;
        for (int k = 0; k < 48; k++) r[k] = din[3 * (k % 16) + k / 16];
        return r;
    endfunction

    function automatic logic [47:0] parity_pat();
        logic [47:0] r;
        for (int j = 0; j < 48; j++) begin
            logic [5:0] jj;
            jj   = 6'(j);
            r[j] = ^jj;
        end
        return r;
    endfunction

    function automatic logic [47:0] obs_word(input int base);
        logic [47:0] r;
        r = '0;
        for (int k = 0; k < 48; k++)
            if (base + k < obs_bit.size()) r[k] = obs_bit[base + k];
        return r;
    endfunction

    function automatic int cyc_at(input int i);
        if (i < obs_cyc.size()) return obs_cyc[i];
        return -1000;
    endfunction

    function automatic logic done_at(input int i);
        if (i < obs_done.size()) return obs_done[i];
        return 1'b0;
    endfunction

    function automatic int done_count();
        int n;
        n = 0;
        for (int i = 0; i < obs_done.size(); i++) if (obs_done[i] === 1'b1) n++;
        return n;
    endfunction

    task automatic clear_log();
        obs_bit.delete();
        obs_cyc.delete();
        obs_done.delete();
        stray_done.delete();
    endtask

    task automatic drive(input logic b, input logic v);
        bus.Input   = b;
        bus.InValid = v;
        @(posedge Clock);
        #1;
        if (v) last_edge = cyc;
    endtask

    task automatic send_symbol(input logic [47:0] bits);
        for (int j = 0; j < 48; j++) drive(bits[j], 1'b1);
        bus.InValid = 1'b0;
    endtask

    task automatic wait_outputs(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (obs_bit.size() >= n) break;
            @(negedge Clock);
            #1;
        end
        if (obs_bit.size() >= n) ok = 1'b1;
    endtask

    task automatic test_reset();
        Reset       = 1'b1;
        bus.Input   = 1'b0;
        bus.InValid = 1'b0;
        bus.Clear   = 1'b0;
        repeat (3) @(posedge Clock);
        #1;
        checks++;
        if (bus.Output !== 1'b0) begin
            errors++;
            $display("FAIL reset_output: got %b expected 0", bus.Output);
        end
        checks++;
        if (bus.OutValid !== 1'b0) begin
            errors++;
            $display("FAIL reset_outvalid: got %b expected 0", bus.OutValid);
        end
        checks++;
        if (bus.SymbolDone !== 1'b0) begin
            errors++;
            $display("FAIL reset_symboldone: got %b expected 0", bus.SymbolDone);
        end
        Reset = 1'b0;
        repeat (5) @(posedge Clock);
        #1;
        checks++;
        if (obs_bit.size() != 0) begin
            errors++;
            $display("FAIL reset_idle: got %0d outputs expected 0", obs_bit.size());
        end
    endtask

    task automatic test_single_one();
        int jv[4] = '{1, 3, 47, 0};
        int kv[4] = '{16, 1, 47, 0};
        for (int i = 0; i < 4; i++) begin
            logic [47:0] bits, exp, dw;
            bit ok;
            int e;
            clear_log();
            bits        = '0;
            bits[jv[i]] = 1'b1;
            exp         = '0;
            exp[kv[i]]  = 1'b1;
            send_symbol(bits);
            e = last_edge;
            wait_outputs(48, 80, ok);
            repeat (4) @(negedge Clock);
            #1;
            checks++;
            if (obs_bit.size() != 48) begin
                errors++;
                $display("FAIL single_count j=%0d: got %0d expected 48", jv[i], obs_bit.size());
            end
            checks++;
            if (obs_word(0) !== exp) begin
                errors++;
                $display("FAIL single_data j=%0d: got %h expected %h", jv[i], obs_word(0), exp);
            end
            checks++;
            if (cyc_at(0) != e + 2) begin
                errors++;
                $display("FAIL single_latency j=%0d: got %0d expected %0d", jv[i], cyc_at(0), e + 2);
            end
            for (int k = 0; k < 48; k++) dw[k] = done_at(k);
            checks++;
            if (dw !== 48'h8000_0000_0000) begin
                errors++;
                $display("FAIL single_done j=%0d: got %h expected %h", jv[i], dw, 48'h8000_0000_0000);
            end
        end
    endtask

    task automatic test_permutation();
        logic [47:0] bits;
        bit ok;
        int e;
        clear_log();
        bits = parity_pat();
        send_symbol(bits);
        e = last_edge;
        wait_outputs(48, 80, ok);
        repeat (4) @(negedge Clock);
        #1;
        checks++;
        if (!ok || obs_word(0) !== deint(bits)) begin
            errors++;
            $display("FAIL perm_data: got %h expected %h", obs_word(0), deint(bits));
        end
        checks++;
        if (cyc_at(47) - cyc_at(0) != 47 || obs_bit.size() != 48) begin
            errors++;
            $display("FAIL perm_contiguous: got span %0d count %0d expected 47 48",
                     cyc_at(47) - cyc_at(0), obs_bit.size());
        end
        checks++;
        if (cyc_at(0) != e + 2) begin
            errors++;
            $display("FAIL perm_latency: got %0d expected %0d", cyc_at(0), e + 2);
        end
    endtask

    task automatic test_back_to_back();
        logic [47:0] pats[3];
        bit ok;
        int e48;
        clear_log();
        pats[0] = parity_pat();
        pats[1] = 48'hF0F0_1234_ABCD;
        pats[2] = ~parity_pat();
        e48     = 0;
        for (int s = 0; s < 3; s++) begin
            for (int j = 0; j < 48; j++) begin
                drive(pats[s][j], 1'b1);
                if (s == 0 && j == 47) e48 = last_edge;
            end
        end
        bus.InValid = 1'b0;
        wait_outputs(144, 250, ok);
        repeat (4) @(negedge Clock);
        #1;
        checks++;
        if (obs_bit.size() != 144) begin
            errors++;
            $display("FAIL b2b_count: got %0d expected 144", obs_bit.size());
        end
        checks++;
        if (cyc_at(0) != e48 + 2) begin
            errors++;
            $display("FAIL b2b_latency: got %0d expected %0d", cyc_at(0), e48 + 2);
        end
        checks++;
        if (cyc_at(143) - cyc_at(0) != 143) begin
            errors++;
            $display("FAIL b2b_contiguous: got span %0d expected 143", cyc_at(143) - cyc_at(0));
        end
        checks++;
        if ({done_at(143), done_at(95), done_at(47)} !== 3'b111 || done_count() != 3) begin
            errors++;
            $display("FAIL b2b_done: got count %0d expected 3 at 47/95/143", done_count());
        end
        for (int s = 0; s < 3; s++) begin
            checks++;
            if (obs_word(48 * s) !== deint(pats[s])) begin
                errors++;
                $display("FAIL b2b_data sym=%0d: got %h expected %h", s, obs_word(48 * s),
                         deint(pats[s]));
            end
        end
    endtask

    task automatic test_gapped();
        logic [47:0] bits;
        bit ok;
        int e;
        clear_log();
        bits = 48'h1357_9BDF_2468;
        for (int c = 0; c < 96; c++) begin
            if (c % 2 == 0) drive(bits[c / 2], 1'b1);
            else            drive(1'b0, 1'b0);
        end
        e = last_edge;
        wait_outputs(48, 80, ok);
        repeat (4) @(negedge Clock);
        #1;
        checks++;
        if (!ok || obs_word(0) !== deint(bits)) begin
            errors++;
            $display("FAIL gap_data: got %h expected %h", obs_word(0), deint(bits));
        end
        checks++;
        if (cyc_at(0) != e + 2 || cyc_at(47) - cyc_at(0) != 47 || obs_bit.size() != 48) begin
            errors++;
            $display("FAIL gap_timing: got start %0d span %0d count %0d expected %0d 47 48",
                     cyc_at(0), cyc_at(47) - cyc_at(0), obs_bit.size(), e + 2);
        end
    endtask

    task automatic test_clear();
        logic [47:0] bits;
        bit ok;
        int e;
        clear_log();
        for (int j = 0; j < 20; j++) drive(1'b1, 1'b1);
        bus.Clear = 1'b1;
        drive(1'b1, 1'b1);
        bus.Clear = 1'b0;
        bits = 48'hC3A5_0F96_7E18;
        send_symbol(bits);
        e = last_edge;
        wait_outputs(48, 80, ok);
        repeat (60) @(negedge Clock);
        #1;
        checks++;
        if (obs_bit.size() != 48) begin
            errors++;
            $display("FAIL clear_count: got %0d expected 48", obs_bit.size());
        end
        checks++;
        if (obs_word(0) !== deint(bits)) begin
            errors++;
            $display("FAIL clear_data: got %h expected %h", obs_word(0), deint(bits));
        end
        checks++;
        if (cyc_at(0) != e + 2) begin
            errors++;
            $display("FAIL clear_latency: got %0d expected %0d", cyc_at(0), e + 2);
        end
    endtask

    task automatic test_clear_last_read();
        logic [47:0] bits;
        bit ok;
        clear_log();
        send_symbol(parity_pat());
        wait_outputs(47, 80, ok);
        bus.Clear = 1'b1;
        @(posedge Clock);
        #1;
        bus.Clear = 1'b0;
        repeat (5) @(negedge Clock);
        #1;
        checks++;
        if (obs_bit.size() != 47 || done_count() != 0 || stray_done.size() != 0) begin
            errors++;
            $display("FAIL clear_last: got count %0d dones %0d stray %0d expected 47 0 0",
                     obs_bit.size(), done_count(), stray_done.size());
        end
        clear_log();
        bits = 48'h0123_4567_89AB;
        send_symbol(bits);
        wait_outputs(48, 80, ok);
        repeat (2) @(negedge Clock);
        #1;
        checks++;
        if (!ok || obs_word(0) !== deint(bits)) begin
            errors++;
            $display("FAIL clear_last_recover: got %h expected %h", obs_word(0), deint(bits));
        end
    endtask

    task automatic test_reset_midread();
        logic [47:0] bits;
        bit ok;
        clear_log();
        send_symbol(48'hFFFF_FFFF_FFFF);
        wait_outputs(11, 80, ok);
        Reset = 1'b1;
        #1;
        checks++;
        if (bus.OutValid !== 1'b0 || bus.Output !== 1'b0) begin
            errors++;
            $display("FAIL reset_midread: got valid %b out %b expected 0 0", bus.OutValid,
                     bus.Output);
        end
        #1;
        Reset = 1'b0;
        repeat (3) @(negedge Clock);
        #1;
        checks++;
        if (obs_bit.size() != 11) begin
            errors++;
            $display("FAIL reset_midread_count: got %0d expected 11", obs_bit.size());
        end
        clear_log();
        bits = 48'h5A5A_1234_9876;
        send_symbol(bits);
        wait_outputs(48, 80, ok);
        repeat (4) @(negedge Clock);
        #1;
        checks++;
        if (obs_bit.size() != 48 || obs_word(0) !== deint(bits)) begin
            errors++;
            $display("FAIL reset_recover: got %h count %0d expected %h 48", obs_word(0),
                     obs_bit.size(), deint(bits));
        end
    endtask

    initial begin
        test_reset();
        test_single_one();
        test_permutation();
        test_back_to_back();
        test_gapped();
        test_clear();
        test_clear_last_read();
        test_reset_midread();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
